// File: rtl/shift_xfer_arbiter_if.sv
// Handshake and serial-link bundle between the requesters and the shift-transfer arbiter.
interface shift_xfer_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic [WIDTH-1:0] data0;
   logic             req1;
   logic [WIDTH-1:0] data1;
   logic             sin;
   logic             sout;
   logic             gnt0;
   logic             gnt1;
   logic             busy;
   logic             done;
   logic             done_id;
   logic [WIDTH-1:0] rx_data;

   modport slave (
      input  req0, data0, req1, data1, sin,
      output sout, gnt0, gnt1, busy, done, done_id, rx_data
   );

   modport master (
      output req0, data0, req1, data1, sin,
      input  sout, gnt0, gnt1, busy, done, done_id, rx_data
   );
endinterface

// File: rtl/shift_xfer_arbiter.sv
// Round-robin owner of one right-shifting register: loads the winner's word,
// shifts it out LSB-first while capturing sin, then reports the captured word.
//
// state | meaning
// IDLE  | sampling requests; a grant loads shreg and moves to SHIFT
// SHIFT | sout = shreg[0]; one bit out and one sin sample per edge, WIDTH edges
// DONE  | one-cycle done pulse; rx_data/done_id already hold the result
module shift_xfer_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   shift_xfer_arbiter_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             owner;
   logic             grant_any;
   logic             grant_id;
   logic             last_shift;
   logic             gnt0_q, gnt1_q, done_id_q;
   logic [WIDTH-1:0] rx_q;

   assign last_shift = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      grant_any = 1'b0;
      grant_id  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               grant_any = 1'b1;
               grant_id  = ~last;
            end else if (bus.req0) begin
               grant_any = 1'b1;
               grant_id  = 1'b0;
            end else if (bus.req1) begin
               grant_any = 1'b1;
               grant_id  = 1'b1;
            end
            if (grant_any) state_nxt = SHIFT;
         end
         SHIFT:   if (last_shift) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         last      <= 1'b1;
         owner     <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done_id_q <= 1'b0;
         rx_q      <= '0;
      end else begin
         state  <= state_nxt;
         gnt0_q <= grant_any && !grant_id;
         gnt1_q <= grant_any && grant_id;
         if (grant_any) begin
            shreg <= grant_id ? bus.data1 : bus.data0;
            last  <= grant_id;
            owner <= grant_id;
            cnt   <= '0;
         end else if (state == SHIFT) begin
            shreg <= {bus.sin, shreg[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
            // Result is latched on the final shift so it is valid throughout DONE.
            if (last_shift) begin
               rx_q      <= {bus.sin, shreg[WIDTH-1:1]};
               done_id_q <= owner;
            end
         end
      end
   end

   assign bus.sout    = (state == SHIFT) ? shreg[0] : 1'b0;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);
   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.done_id = done_id_q;
   assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_shift_xfer_arbiter.sv
// Self-checking bench for shift_xfer_arbiter: vector table, corner sequences, random traffic vs a transfer-level model.
module tb_shift_xfer_arbiter;
   localparam int W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   shift_xfer_arbiter_if #(.WIDTH(W)) bus ();
   shift_xfer_arbiter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;

   // Reference model: position within a transfer (0 = idle, 1..W = bit k-1 on the wire, W+1 = done).
   int           m_pos;
   int           m_last;
   int           m_owner;
   logic [W-1:0] m_tx, m_rx, e_rx;
   logic         e_id;

   typedef struct {
      logic         rst, r0, r1;
      logic [W-1:0] d0, d1;
      logic         s;
      logic [W+5:0] exp;
   } vec_t;
   vec_t tbl[8];

   function automatic logic [W+5:0] pack(logic g0, logic g1, logic b, logic d, logic id, logic so,
                                         logic [W-1:0] rx);
      return {g0, g1, b, d, id, so, rx};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W+5:0] dut_vec();
      return pack(bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.sout, bus.rx_data);
   endfunction

   // One clock: capture inputs, advance DUT and model, compare just after the edge.
   task automatic step();
      logic         r, q0, q1, s;
      logic [W-1:0] d0, d1;
      int           id;
      logic         eg0, eg1, eso;
      r = reset; q0 = bus.req0; q1 = bus.req1; s = bus.sin; d0 = bus.data0; d1 = bus.data1;
      @(posedge clk);
      if (r) begin
         m_pos = 0; m_last = 1; e_rx = '0; e_id = 1'b0;
      end else if (m_pos == 0) begin
         id = -1;
         if (q0 && q1) id = 1 - m_last;
         else if (q0)  id = 0;
         else if (q1)  id = 1;
         if (id >= 0) begin
            m_pos = 1; m_owner = id; m_last = id;
            m_tx = (id == 1) ? d1 : d0;
            m_rx = '0;
         end
      end else if (m_pos <= W) begin
         m_rx[m_pos-1] = s;
         m_pos++;
         if (m_pos == W + 1) begin
            e_rx = m_rx; e_id = m_owner[0];
         end
      end else begin
         m_pos = 0;
      end
      #1;
      eg0 = (m_pos == 1) && (m_owner == 0);
      eg1 = (m_pos == 1) && (m_owner == 1);
      eso = (m_pos >= 1 && m_pos <= W) ? m_tx[m_pos-1] : 1'b0;
      check("cycle", 64'(dut_vec()),
            64'(pack(eg0, eg1, m_pos != 0, m_pos == W + 1, e_id, eso, e_rx)));
      check("excl", 64'((bus.gnt0 & bus.gnt1) | (bus.done & (bus.gnt0 | bus.gnt1))), 64'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   initial begin
      int gcount, prev_id, prev_t, t, n, seen;
      bit ok;
      reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0; bus.sin = 1'b0;
      m_pos = 0; m_last = 1; m_owner = 0; m_tx = '0; m_rx = '0; e_rx = '0; e_id = 1'b0;

      // Reset with both requests held, release -> requester 0 wins, then the 1010 transfer.
      tbl[0] = '{1, 1, 1, 4'hA, 4'h5, 0, pack(0, 0, 0, 0, 0, 0, 4'h0)};
      tbl[1] = '{1, 1, 1, 4'hA, 4'h5, 0, pack(0, 0, 0, 0, 0, 0, 4'h0)};
      tbl[2] = '{0, 1, 1, 4'hA, 4'h5, 0, pack(1, 0, 1, 0, 0, 0, 4'h0)};
      tbl[3] = '{0, 0, 0, 4'hA, 4'h5, 1, pack(0, 0, 1, 0, 0, 1, 4'h0)};
      tbl[4] = '{0, 0, 0, 4'hA, 4'h5, 1, pack(0, 0, 1, 0, 0, 0, 4'h0)};
      tbl[5] = '{0, 0, 0, 4'hA, 4'h5, 0, pack(0, 0, 1, 0, 0, 1, 4'h0)};
      tbl[6] = '{0, 0, 0, 4'hA, 4'h5, 1, pack(0, 0, 1, 1, 0, 0, 4'hB)};
      tbl[7] = '{0, 0, 0, 4'hA, 4'h5, 0, pack(0, 0, 0, 0, 0, 0, 4'hB)};
      for (int i = 0; i < 8; i++) begin
         reset = tbl[i].rst; bus.req0 = tbl[i].r0; bus.req1 = tbl[i].r1;
         bus.data0 = tbl[i].d0; bus.data1 = tbl[i].d1; bus.sin = tbl[i].s;
         step();
         check($sformatf("vec%0d", i), 64'(dut_vec()), 64'(tbl[i].exp));
      end

      // Continuous dual requests: strict alternation with a W+2 cycle period.
      do_reset();
      bus.data0 = '1; bus.data1 = '0; bus.sin = 1'b0;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      gcount = 0; prev_id = 1; prev_t = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (bus.busy && !bus.done) check("sout_owner", 64'(bus.sout), 64'(m_owner == 0));
         if (bus.gnt0 || bus.gnt1) begin
            t = bus.gnt1 ? 1 : 0;
            check("alternate", 64'(t), 64'(1 - prev_id));
            if (gcount > 0) check("period", 64'(c - prev_t), 64'(W + 2));
            prev_id = t; prev_t = c; gcount++;
         end
      end
      check("grant_count", 64'(gcount >= 4), 64'(1));
      bus.req0 = 1'b0; bus.req1 = 1'b0;

      // req1 raised mid-transfer of requester 0 is held off until the arbiter is idle again.
      do_reset();
      bus.data0 = 4'h6; bus.data1 = 4'h9; bus.req0 = 1'b1;
      ok = 0;
      for (int c = 0; c < 5 && !ok; c++) begin step(); if (bus.gnt0) ok = 1; end
      check("gnt0_seen", 64'(ok), 64'(1));
      bus.req0 = 1'b0;
      step();
      bus.req1 = 1'b1;
      ok = 0; seen = 0;
      for (int c = 0; c < 3 * W && !ok; c++) begin
         step();
         if (bus.gnt1) seen = 1;
         if (bus.done) ok = 1;
      end
      check("done_seen", 64'(ok), 64'(1));
      check("no_early_gnt1", 64'(seen), 64'(0));
      n = 0; ok = 0;
      for (int c = 0; c < 5 && !ok; c++) begin step(); n++; if (bus.gnt1) ok = 1; end
      check("gnt1_after_done", 64'(ok ? n : -1), 64'(2));
      bus.req1 = 1'b0;
      while (bus.busy && n < 20) begin step(); n++; end

      // Reset during the second SHIFT cycle aborts the transfer with no done.
      do_reset();
      bus.data0 = 4'hF; bus.req0 = 1'b1;
      step();
      bus.req0 = 1'b0;
      step();
      check("in_shift", 64'({bus.busy, bus.done}), 64'(2'b10));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_busy_sout", 64'({bus.busy, bus.sout}), 64'(0));
      seen = 0;
      for (int c = 0; c < 10; c++) begin step(); if (bus.done) seen = 1; end
      check("abort_no_done", 64'(seen), 64'(0));
      check("abort_rx", 64'(bus.rx_data), 64'(0));

      // Ten idle cycles after reset: nothing moves.
      do_reset();
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (bus.busy || bus.sout || bus.gnt0 || bus.gnt1 || bus.done) seen = 1;
      end
      check("idle_quiet", 64'(seen), 64'(0));

      // Random traffic, with occasional resets, against the model.
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0) bus.req0 = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) bus.req1 = $urandom_range(0, 1);
         bus.data0 = W'($urandom); bus.data1 = W'($urandom); bus.sin = $urandom_range(0, 1);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
